fir_decim_requant: RTL and testbench
====================================

# fir_decim_requant

Downstream companion to `fir_filter`. Consumes the filter's free-running 12-bit signed output and applies boxcar decimation: it sums `DECIM` consecutive samples, then scales, rounds and saturates the sum to 8-bit signed. Results go out through a small first-word-fall-through FIFO with a valid/ready interface toward the next consumer. The input side cannot be stalled, so results that arrive while the FIFO is full are dropped and counted.

## Interface
- `IN_W`, 12: input sample width (signed, two's complement)
- `OUT_W`, 8: output sample width (signed)
- `DECIM`, 4: samples per output; power of two, ≥2
- `SHIFT`, 6: arithmetic right shift applied to the block sum; ≥1
- `FIFO_DEPTH`, 4: output FIFO entries; power of two
- `clk`  in  1  sole clock, rising edge
- `reset`  in  1  asynchronous, active-high; clears all state
- `in_valid`  in  1  `in_data` is a new sample this cycle
- `in_data`  in  IN_W  signed sample from the FIR
- `out_valid`  out  1  FIFO non-empty
- `out_ready`  in  1  consumer accepts `out_data` this cycle
- `out_data`  out  OUT_W  signed head-of-FIFO sample
- `fifo_level`  out  clog2(FIFO_DEPTH)+1  current occupancy
- `sat_cnt`  out  8  count of saturated results, sticks at 255
- `drop_cnt`  out  8  count of results dropped on a full FIFO, sticks at 255

## Operation
- Phase counter `0..DECIM-1` and accumulator of width `IN_W+clog2(DECIM)` (14 bits at the defaults). Both advance only on `in_valid`.
- Phase 0: the accumulator loads `in_data`. Other phases: it adds `in_data`.
- On the accepted sample where phase = `DECIM-1`:
  - `sum = acc + in_data`.
  - `r = (sum + 2^(SHIFT-1)) >>> SHIFT`, using an arithmetic shift. This rounds half toward +∞.
  - `r` is clamped to [-2^(OUT_W-1), 2^(OUT_W-1)-1]. A clamp increments `sat_cnt`.
  - The result is pushed into the FIFO and the phase returns to 0.
- No intermediate overflow is possible: all internal widths are sized for a full-scale sum.
- Push/pop rules:
  - A pop occurs when `out_valid && out_ready`.
  - A push with the FIFO full and no pop in the same cycle is dropped and increments `drop_cnt`.
  - A push with the FIFO full and a pop in the same cycle is accepted: the level stays at `FIFO_DEPTH` and nothing is dropped.
  - A pop on an empty FIFO is ignored.
- If one result both saturates and is dropped, both counters increment.
- `in_valid` low leaves the phase and accumulator unchanged (gaps are allowed).
- FIFO: read and write pointers of clog2 depth that wrap modulo `FIFO_DEPTH`, plus an explicit level counter.

## Timing
- Reset values:
  - `out_valid` = 0, `out_data` = 0, `fifo_level` = 0, `sat_cnt` = 0, `drop_cnt` = 0.
  - Phase = 0, accumulator = 0.
  - Reset is asserted asynchronously and released synchronously to `clk` by the system.
- Reset mid-block discards the partial sum. The next accepted sample is phase 0.
- Latency: `out_valid` rises in the cycle after the edge that accepts the `DECIM`-th sample (1 cycle), when the FIFO was empty.
- `out_data` is combinational from the FIFO head. It is stable while `out_valid && !out_ready`.
- `fifo_level`, `sat_cnt` and `drop_cnt` update on the same edge as the push or pop that changes them.
- Throughput: one result per `DECIM` input samples, with `in_valid` allowed every cycle.

## Configuration
- `DECIM_ROUND_EN` defined: rounding as described in Operation (add `2^(SHIFT-1)` before the shift).
- `DECIM_ROUND_EN` undefined: no rounding offset is added, so `r = sum >>> SHIFT` (floor, truncation toward −∞). Saturation, counters and timing are unchanged.

## Test plan
All cases use default parameters.
- Four samples of 200, `out_ready`=1: sum 800 → out_data 13 with `DECIM_ROUND_EN`, 12 without. `out_valid` pulses for one cycle, asserting the cycle after the 4th sample.
- Four samples of -100: sum -400 → -6 with `DECIM_ROUND_EN`, -7 without. `sat_cnt` stays 0.
- Four samples of 2047: sum 8188 → rounded 128 clamps to 127, `sat_cnt`=1. Four samples of -2048: sum -8192 → -128, `sat_cnt` still 1.
- `out_ready`=0, 20 samples of 200 (5 results):
  - `fifo_level`=4 and `drop_cnt`=1.
  - Then raise `out_ready`: four outputs of 13, after which `out_valid`=0.
  - In a separate run with the FIFO full, align a push with a pop: no drop occurs and the level stays at 4.
- Two samples of 2047, then assert `reset` for 2 cycles, then four samples of 200:
  - Outputs and counters are 0 during reset.
  - The single result afterward is 13, with no contamination from the pre-reset samples.
- `in_valid` toggling 1/0 across eight 200-valued samples: two results of 13, each one cycle after the 4th and 8th accepted samples.

Source files
------------

// File: rtl/fir_decim_requant_if.sv
// rtl/fir_decim_requant_if.sv - sample-in / result-out handshake bundle for fir_decim_requant
//   in_valid, in_data   : free-running signed samples from the FIR (no back-pressure)
//   out_valid, out_ready: valid/ready handshake toward the next consumer
//   out_data            : signed head-of-FIFO result
//   master: the side that supplies samples and consumes results
//   slave : the decimator
interface fir_decim_requant_if #(
    parameter int IN_W  = 12,
    parameter int OUT_W = 8
);
    logic             in_valid;
    logic [IN_W-1:0]  in_data;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;

    modport master (
        output in_valid, in_data, out_ready,
        input  out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output out_valid, out_data
    );
endinterface

// File: rtl/fir_decim_requant.sv
// rtl/fir_decim_requant.sv - boxcar decimator with shift/round/saturate requantiser and FWFT output FIFO
//   clk        : sole clock, rising edge
//   reset      : asynchronous active-high, clears all state
//   bus        : fir_decim_requant_if.slave (in_valid/in_data in, out_valid/out_ready/out_data out)
//   fifo_level : current FIFO occupancy
//   sat_cnt    : results that were clamped, sticks at 255
//   drop_cnt   : results lost on a full FIFO, sticks at 255
//   Macro DECIM_ROUND_EN: add 2^(SHIFT-1) before the shift (round half up); undefined = floor.
module fir_decim_requant #(
    parameter int IN_W       = 12,
    parameter int OUT_W      = 8,
    parameter int DECIM      = 4,
    parameter int SHIFT      = 6,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                            clk,
    input  logic                            reset,
    fir_decim_requant_if.slave              bus,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
    output logic [7:0]                      sat_cnt,
    output logic [7:0]                      drop_cnt
);
    localparam int ACC_W = IN_W + $clog2(DECIM);
    // One extra bit so the rounding offset cannot wrap a full-scale positive sum.
    localparam int RND_W = ACC_W + 1;
    localparam int PH_W  = $clog2(DECIM);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;

    localparam logic signed [RND_W-1:0] SAT_MAX = RND_W'((2 ** (OUT_W - 1)) - 1);
    localparam logic signed [RND_W-1:0] SAT_MIN = RND_W'(-(2 ** (OUT_W - 1)));
`ifdef DECIM_ROUND_EN
    localparam logic signed [RND_W-1:0] RND_OFS = RND_W'(2 ** (SHIFT - 1));
`else
    localparam logic signed [RND_W-1:0] RND_OFS = '0;
`endif

    logic [PH_W-1:0]         phase_q, phase_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic signed [ACC_W-1:0] in_ext, sum;
    logic signed [RND_W-1:0] sum_ext, biased, shifted;
    logic                    sat_hit;
    logic [OUT_W-1:0]        res;

    logic                    last, pop, full, push_ok, drop;
    logic [OUT_W-1:0]        mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]        wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0]        level_q, level_d;
    logic [7:0]              sat_q, sat_d, drop_q, drop_d;

    always_comb begin
        in_ext  = {{(ACC_W - IN_W){bus.in_data[IN_W-1]}}, bus.in_data};
        sum     = acc_q + in_ext;
        sum_ext = {sum[ACC_W-1], sum};
        biased  = sum_ext + RND_OFS;
        shifted = biased >>> SHIFT;

        sat_hit = 1'b0;
        res     = shifted[OUT_W-1:0];
        if (shifted > SAT_MAX) begin
            sat_hit = 1'b1;
            res     = SAT_MAX[OUT_W-1:0];
        end else if (shifted < SAT_MIN) begin
            sat_hit = 1'b1;
            res     = SAT_MIN[OUT_W-1:0];
        end

        last    = bus.in_valid && (phase_q == PH_W'(DECIM - 1));
        pop     = bus.out_ready && (level_q != '0);
        full    = (level_q == LVL_W'(FIFO_DEPTH));
        // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
        push_ok = last && (!full || pop);
        drop    = last && full && !pop;

        phase_d = phase_q;
        acc_d   = acc_q;
        if (bus.in_valid) begin
            // DECIM is a power of two, so the phase wraps naturally.
            phase_d = phase_q + PH_W'(1);
            acc_d   = (phase_q == '0) ? in_ext : sum;
        end

        level_d = level_q;
        if (push_ok && !pop) begin
            level_d = level_q + LVL_W'(1);
        end else if (!push_ok && pop) begin
            level_d = level_q - LVL_W'(1);
        end

        sat_d = sat_q;
        if (last && sat_hit && (sat_q != 8'hFF)) begin
            sat_d = sat_q + 8'd1;
        end

        drop_d = drop_q;
        if (drop && (drop_q != 8'hFF)) begin
            drop_d = drop_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase_q  <= '0;
            acc_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            sat_q    <= '0;
            drop_q   <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            phase_q <= phase_d;
            acc_q   <= acc_d;
            level_q <= level_d;
            sat_q   <= sat_d;
            drop_q  <= drop_d;
            if (push_ok) begin
                mem_q[wr_ptr_q] <= res;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
        end
    end

    assign bus.out_valid = (level_q != '0);
    assign bus.out_data  = mem_q[rd_ptr_q];
    assign fifo_level    = level_q;
    assign sat_cnt       = sat_q;
    assign drop_cnt      = drop_q;
endmodule

// File: tb/tb_fir_decim_requant.sv
// tb/tb_fir_decim_requant.sv - scoreboard bench for fir_decim_requant
module tb_fir_decim_requant;
`ifdef DECIM_ROUND_EN
    localparam int E200  = 13;
    localparam int EN100 = -6;
    localparam int SAT1  = 1;
`else
    localparam int E200  = 12;
    localparam int EN100 = -7;
    localparam int SAT1  = 0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] fifo_level, fifo_level2;
    logic [7:0] sat_cnt, drop_cnt, sat_cnt2, drop_cnt2;

    int checks = 0;
    int errors = 0;
    int exp_q[$];

    fir_decim_requant_if #(.IN_W(12), .OUT_W(8)) bus ();
    fir_decim_requant_if #(.IN_W(12), .OUT_W(8)) bus2 ();

    // Second instance with a small shift so saturation is reachable in both rounding modes.
    assign bus2.in_valid  = bus.in_valid;
    assign bus2.in_data   = bus.in_data;
    assign bus2.out_ready = 1'b1;

    fir_decim_requant dut (
        .clk(clk), .reset(rst), .bus(bus.slave),
        .fifo_level(fifo_level[2:0]), .sat_cnt(sat_cnt), .drop_cnt(drop_cnt)
    );

    fir_decim_requant #(.SHIFT(4)) dut_sat (
        .clk(clk), .reset(rst), .bus(bus2.slave),
        .fifo_level(fifo_level2[2:0]), .sat_cnt(sat_cnt2), .drop_cnt(drop_cnt2)
    );

    assign fifo_level[3]  = 1'b0;
    assign fifo_level2[3] = 1'b0;

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual %0d required %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_output", int'($signed(bus.out_data)), 9999);
            end else begin
                chk("out_data", int'($signed(bus.out_data)), exp_q.pop_front());
            end
        end
    end

    task automatic smp(input int v);
        bus.in_valid = 1'b1;
        bus.in_data  = v[11:0];
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic blk(input int v, input int e);
        for (int i = 0; i < 3; i++) smp(v);
        exp_q.push_back(e);
        smp(v);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (exp_q.size() == 0) break;
            @(posedge clk);
            #1;
        end
        chk("drain_left", exp_q.size(), 0);
        @(negedge clk);
        chk("drained_valid", bus.out_valid, 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", bus.out_valid, 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_sat", sat_cnt, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // 200 x4: latency and one-cycle pulse
        blk(200, E200);
        @(negedge clk);
        chk("lat_valid", bus.out_valid, 1);
        @(negedge clk);
        chk("pulse_end", bus.out_valid, 0);
        idle(1);

        // -100 x4
        blk(-100, EN100);
        idle(3);
        chk("sat_after_neg", sat_cnt, 0);

        // full-scale blocks
        blk(2047, 127);
        blk(-2048, -128);
        idle(3);
        chk("sat_full_scale", sat_cnt, SAT1);
        chk("sat2_count", sat_cnt2, 2);
        chk("drop2_count", drop_cnt2, 0);

        // back-pressure: 5 results into a 4-deep FIFO
        bus.out_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (i % 4 == 3 && i < 16) exp_q.push_back(E200);
            smp(200);
        end
        chk("full_level", fifo_level, 4);
        chk("full_drop", drop_cnt, 1);
        @(negedge clk);
        chk("full_head", int'($signed(bus.out_data)), E200);
        drain();

        // full FIFO, push aligned with pop
        bus.out_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (i % 4 == 3) exp_q.push_back(E200);
            smp(200);
        end
        chk("align_pre_level", fifo_level, 4);
        for (int i = 0; i < 3; i++) smp(200);
        exp_q.push_back(E200);
        bus.out_ready = 1'b1;
        smp(200);
        bus.out_ready = 1'b0;
        chk("align_level", fifo_level, 4);
        chk("align_drop", drop_cnt, 1);
        drain();

        // reset mid-block
        smp(2047);
        smp(2047);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_valid", bus.out_valid, 0);
        chk("mid_rst_data", int'(bus.out_data), 0);
        chk("mid_rst_level", fifo_level, 0);
        chk("mid_rst_sat", sat_cnt, 0);
        chk("mid_rst_drop", drop_cnt, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        blk(200, E200);
        drain();

        // in_valid toggling
        for (int i = 0; i < 8; i++) begin
            if (i % 4 == 3) exp_q.push_back(E200);
            smp(200);
            if (i % 4 == 3) begin
                @(negedge clk);
                chk("gap_valid", bus.out_valid, 1);
            end
            @(posedge clk);
            #1;
        end
        idle(5);
        chk("final_queue", exp_q.size(), 0);
        chk("final_drop", drop_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
